// File: rtl/btn_irq_pkg.sv
// Shared constants and types for the button interrupt controller.
// The defaults are used when the controller is instantiated without parameters.
package btn_irq_pkg;

    localparam int DEF_NUM_BTN         = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_ID_W            = (DEF_NUM_BTN > 1) ? $clog2(DEF_NUM_BTN) : 1;

    typedef logic [DEF_NUM_BTN-1:0] btn_vec_t;
    typedef logic [DEF_ID_W-1:0]    irq_id_t;

    // Counter width able to hold 0..cycles without wrapping.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/btn_irq_ctrl_debounce.sv
// One button: two-flop synchronizer, mismatch counter and accepted level.
// o_rise is high during the cycle whose closing edge raises o_stable.
module btn_debounce
    import btn_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_stable,
    output logic o_rise
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_flip;

    // The mismatch has already lasted DEBOUNCE_CYCLES-1 edges; this edge makes it count.
    assign w_flip = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_flip & r_sync2;

endmodule

// File: rtl/btn_irq_ctrl.sv
// Button interrupt controller: debounced press events latch pending bits,
// a masked lowest-index-first request goes to the core, ack clears the served bit.
module btn_irq_ctrl
    import btn_irq_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ID_W            = $clog2(NUM_BTN)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_BTN-1:0] i_io_btn,
    input  logic               i_ack,
    input  logic               i_mask_we,
    input  logic [NUM_BTN-1:0] i_mask_wdata,
    output logic               o_irq,
    output logic [ID_W-1:0]    o_irq_id,
    output logic [NUM_BTN-1:0] o_pending,
    output logic [NUM_BTN-1:0] o_mask,
    output logic [NUM_BTN-1:0] o_btn_stable
);

    logic [NUM_BTN-1:0] w_stable;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_active;
    logic [NUM_BTN-1:0] w_ack_clr;
    logic [ID_W-1:0]    w_irq_id;
    logic               w_irq;

    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] r_mask;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_btn    (i_io_btn[g]),
            .o_stable (w_stable[g]),
            .o_rise   (w_rise[g])
        );
    end

    assign w_active = r_pending & r_mask;
    assign w_irq    = |w_active;

    // Scan from the top so the lowest enabled index is the last to write.
    always_comb begin
        w_irq_id = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_active[i]) w_irq_id = ID_W'(i);
        end
    end

    always_comb begin
        w_ack_clr = '0;
        if (i_ack && w_irq) w_ack_clr[w_irq_id] = 1'b1;
    end

    // A press landing on the same edge as its ack re-sets the bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_pending <= (r_pending & ~w_ack_clr) | w_rise;
            if (i_mask_we) r_mask <= i_mask_wdata;
        end
    end

    assign o_irq        = w_irq;
    assign o_irq_id     = w_irq_id;
    assign o_pending    = r_pending;
    assign o_mask       = r_mask;
    assign o_btn_stable = w_stable;

endmodule
